cmd_parser: RTL and testbench

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser_pkg.sv | 23 ++
 rtl/rx_timeout.sv | 40 ++++
 rtl/cmd_parser.sv | 143 ++++++++++++++
 tb/tb_cmd_parser.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_parser_pkg.sv
// Shared types and constants for the UART command parser.
// Optional timeout support is selected with LOGIP_RX_TIMEOUT_EN (see rx_timeout).
package cmd_parser_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArg,
    StExec,
    StIdTx
  } state_e;

  localparam logic [7:0] OPC_RESET = 8'h00;
  localparam logic [7:0] OPC_RUN   = 8'h01;
  localparam logic [7:0] OPC_ID    = 8'h02;

  localparam int unsigned LONG_BIT = 7;

  // Byte idx of a 32-bit word, byte 0 being the least significant.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rx_timeout.sv
// Idle-cycle watchdog for the argument phase of long commands.
// Only counts when LOGIP_RX_TIMEOUT_EN is defined; otherwise expired_o is constant 0.
module rx_timeout #(
  parameter int unsigned Limit = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

`ifdef LOGIP_RX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Fires on the Limit-th consecutive idle cycle; a byte in that cycle wins.
  always_comb begin
    expired_o = en_i && !clr_i && (cnt_q == CntW'(Limit - 1));
    cnt_d     = cnt_q + 1'b1;
    if (!en_i || clr_i || expired_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk_i, rst_ni, en_i, clr_i};
  assign expired_o     = 1'b0;
`endif

endmodule

// File: rtl/cmd_parser.sv
// UART byte-stream command decoder: short (1-byte) and long (opcode + 4 arg bytes) commands,
// soft reset and ID readout. Argument timeout enabled by LOGIP_RX_TIMEOUT_EN.
module cmd_parser
  import cmd_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [31:0] ID_WORD        = 32'h534C4131
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        rx_stb_i,
  input  logic [7:0]  rx_i,
  input  logic        tx_rdy_i,
  output logic        exec_o,
  output logic [7:0]  opc_o,
  output logic [31:0] arg_o,
  output logic        soft_rst_o,
  output logic        tx_stb_o,
  output logic [7:0]  tx_o,
  output logic        err_o
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] part_q, part_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  opc_q, opc_d;
  logic [31:0] arg_q, arg_d;
  logic        tx_stb_q, tx_stb_d;
  logic [7:0]  tx_q, tx_d;
  logic        err_q, err_d;
  logic        timeout;

  rx_timeout #(
    .Limit(TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_in),
    .en_i     (state_q == StArg),
    .clr_i    (rx_stb_i),
    .expired_o(timeout)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    part_d     = part_q;
    cnt_d      = cnt_q;
    opc_d      = opc_q;
    arg_d      = arg_q;
    tx_stb_d   = 1'b0;
    tx_d       = tx_q;
    err_d      = 1'b0;
    exec_o     = 1'b0;
    soft_rst_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_stb_i) begin
          cmd_d = rx_i;
          cnt_d = '0;
          if (rx_i[LONG_BIT]) begin
            state_d = StArg;
          end else begin
            state_d = StExec;
            // ID requests are not reported, so the visible opcode/arg must not move.
            if (rx_i != OPC_ID) begin
              opc_d = rx_i;
              arg_d = '0;
            end
          end
        end
      end
      StArg: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (rx_stb_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            opc_d   = cmd_q;
            arg_d   = {rx_i, part_q};
            state_d = StExec;
          end else begin
            part_d[{cnt_q, 3'b000} +: 8] = rx_i;
          end
        end
      end
      StExec: begin
        if (cmd_q == OPC_ID) begin
          cnt_d   = '0;
          state_d = StIdTx;
        end else begin
          exec_o     = 1'b1;
          soft_rst_o = (cmd_q == OPC_RESET);
          state_d    = StIdle;
        end
      end
      StIdTx: begin
        if (tx_rdy_i && !tx_stb_q) begin
          tx_stb_d = 1'b1;
          tx_d     = word_byte(ID_WORD, cnt_q);
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      opc_q    <= '0;
      arg_q    <= '0;
      tx_stb_q <= 1'b0;
      tx_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      part_q   <= part_d;
      cnt_q    <= cnt_d;
      opc_q    <= opc_d;
      arg_q    <= arg_d;
      tx_stb_q <= tx_stb_d;
      tx_q     <= tx_d;
      err_q    <= err_d;
    end
  end

  assign opc_o    = opc_q;
  assign arg_o    = arg_q;
  assign tx_stb_o = tx_stb_q;
  assign tx_o     = tx_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Self-checking bench for cmd_parser: vector table, hand-written corner sequences and
// randomized commands against a byte-level reference model. Honours LOGIP_RX_TIMEOUT_EN.
module tb_cmd_parser;

  localparam logic [31:0] IdWord = 32'h534C4131;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_stb = 1'b0;
  logic [7:0]  rx = 8'h00;
  logic        tx_rdy = 1'b1;
  logic        exec_o, soft_rst_o, tx_stb_o, err_o;
  logic [7:0]  opc_o, tx_o;
  logic [31:0] arg_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exec_cnt = 0, srst_cnt = 0, err_cnt = 0;
  logic [7:0]  txq[$];

  cmd_parser #(
    .TIMEOUT_CYCLES(16),
    .ID_WORD       (IdWord)
  ) dut (
    .clk_i     (clk),
    .rst_in    (rst_n),
    .rx_stb_i  (rx_stb),
    .rx_i      (rx),
    .tx_rdy_i  (tx_rdy),
    .exec_o    (exec_o),
    .opc_o     (opc_o),
    .arg_o     (arg_o),
    .soft_rst_o(soft_rst_o),
    .tx_stb_o  (tx_stb_o),
    .tx_o      (tx_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter model: busy for the cycle following each accepted byte.
  initial forever begin
    @(negedge clk);
    tx_rdy = !tx_stb_o;
  end

  // Pulse monitor, sampled on the falling edge.
  initial begin
    logic prev_stb;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (exec_o) exec_cnt++;
      if (err_o) err_cnt++;
      if (soft_rst_o) begin
        srst_cnt++;
        check("srst_with_exec", {31'd0, exec_o}, 32'd1);
      end
      if (tx_stb_o) begin
        txq.push_back(tx_o);
        check("tx_stb_gap", {31'd0, prev_stb}, 32'd0);
      end
      prev_stb = tx_stb_o;
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_stb = 1'b1;
    rx     = b;
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_exec"}, {31'd0, exec_o}, 32'd0);
    check({tag, "_opc"}, {24'd0, opc_o}, 32'd0);
    check({tag, "_arg"}, arg_o, 32'd0);
    check({tag, "_srst"}, {31'd0, soft_rst_o}, 32'd0);
    check({tag, "_txstb"}, {31'd0, tx_stb_o}, 32'd0);
    check({tag, "_tx"}, {24'd0, tx_o}, 32'd0);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
  endtask

  // Waits (bounded) for the four ID bytes and checks them against IdWord, LSB first.
  task automatic expect_id(input string tag);
    int unsigned guard;
    guard = 0;
    while (txq.size() < 4 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check({tag, "_id_count"}, txq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < txq.size()) check({tag, "_id_byte"}, {24'd0, txq[i]}, (IdWord >> (8 * i)) & 32'hFF);
    end
    idle(3);
    check({tag, "_id_extra"}, txq.size(), 32'd4);
  endtask

  typedef struct {
    int unsigned n;
    logic [39:0] bytes;
    logic [7:0]  opc;
    logic [31:0] arg;
    logic        srst;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int unsigned e0;
    logic [7:0]  m_opc;
    logic [31:0] m_arg;

    vecs[0] = '{n: 1, bytes: 40'h01, opc: 8'h01, arg: 32'h0, srst: 1'b0};
    vecs[1] = '{n: 5, bytes: 40'h12345678C0, opc: 8'hC0, arg: 32'h12345678, srst: 1'b0};
    vecs[2] = '{n: 1, bytes: 40'h00, opc: 8'h00, arg: 32'h0, srst: 1'b1};
    vecs[3] = '{n: 1, bytes: 40'h7F, opc: 8'h7F, arg: 32'h0, srst: 1'b0};
    vecs[4] = '{n: 5, bytes: 40'h80000000FF, opc: 8'hFF, arg: 32'h80000000, srst: 1'b0};
    vecs[5] = '{n: 5, bytes: 40'hDEADBEEF81, opc: 8'h81, arg: 32'hDEADBEEF, srst: 1'b0};

    // Reset state.
    idle(2);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Vector table: decode latency, pulse width and hold behaviour.
    foreach (vecs[v]) begin
      e0 = exec_cnt;
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].bytes[8*i +: 8]);
        if (i < vecs[v].n - 1) check("vec_early_exec", {31'd0, exec_o}, 32'd0);
      end
      check("vec_exec", {31'd0, exec_o}, 32'd1);
      check("vec_opc", {24'd0, opc_o}, {24'd0, vecs[v].opc});
      check("vec_arg", arg_o, vecs[v].arg);
      check("vec_srst", {31'd0, soft_rst_o}, {31'd0, vecs[v].srst});
      idle(2);
      check("vec_exec_once", exec_cnt - e0, 32'd1);
      check("vec_opc_hold", {24'd0, opc_o}, {24'd0, vecs[v].opc});
      check("vec_arg_hold", arg_o, vecs[v].arg);
    end

    // ID readout with bytes arriving during ID_TX that must be ignored.
    txq.delete();
    e0 = exec_cnt;
    send(8'h02);
    check("id_exec", {31'd0, exec_o}, 32'd0);
    send(8'h01);
    send(8'h85);
    expect_id("id");
    check("id_no_exec", exec_cnt - e0, 32'd0);
    check("id_opc_hold", {24'd0, opc_o}, 32'h81);
    check("id_arg_hold", arg_o, 32'hDEADBEEF);

    // Byte landing in the EXEC cycle is dropped.
    e0 = exec_cnt;
    @(negedge clk);
    rx_stb = 1'b1;
    rx     = 8'h05;
    @(negedge clk);
    rx     = 8'h7E;
    @(negedge clk);
    rx_stb = 1'b0;
    idle(3);
    check("exec_drop_cnt", exec_cnt - e0, 32'd1);
    check("exec_drop_opc", {24'd0, opc_o}, 32'h05);

    // Argument timeout behaviour.
    e0 = exec_cnt;
    send(8'h80);
    send(8'hAA);
    idle(20);
`ifdef LOGIP_RX_TIMEOUT_EN
    check("to_err_once", err_cnt, 32'd1);
    check("to_no_exec", exec_cnt - e0, 32'd0);
    send(8'h01);
    check("to_after_exec", {31'd0, exec_o}, 32'd1);
    check("to_after_opc", {24'd0, opc_o}, 32'h01);
    check("to_after_arg", arg_o, 32'h0);
`else
    check("nto_no_exec", exec_cnt - e0, 32'd0);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    check("nto_exec", {31'd0, exec_o}, 32'd1);
    check("nto_opc", {24'd0, opc_o}, 32'h80);
    check("nto_arg", arg_o, 32'hDDCCBBAA);
    check("nto_err", err_cnt, 32'd0);
`endif
    idle(2);

    // Reset in the middle of a long command.
    send(8'hC0);
    send(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_arg");
    idle(2);
    rst_n = 1'b1;
    send(8'h01);
    check("rst_arg_exec", {31'd0, exec_o}, 32'd1);
    check("rst_arg_opc", {24'd0, opc_o}, 32'h01);
    check("rst_arg_arg", arg_o, 32'h0);
    idle(2);

    // Reset in the middle of the ID transfer.
    txq.delete();
    send(8'h02);
    for (int g = 0; g < 20 && txq.size() == 0; g++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_id");
    idle(3);
    rst_n = 1'b1;
    idle(10);
    check("rst_id_bytes", txq.size(), 32'd1);

    // Randomized commands against the byte-level model.
    apply_reset();
    m_opc = 8'h00;
    m_arg = 32'h0;
    for (int c = 0; c < 60; c++) begin
      logic [7:0]  b[5];
      int unsigned n, k;
      logic [31:0] arg;
      k = $urandom_range(0, 9);
      b[0] = (k == 0) ? 8'h00 : (k == 1) ? 8'h02 :
             (k < 6) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
      n = b[0][7] ? 5 : 1;
      arg = 32'h0;
      for (int i = 1; i < 5; i++) begin
        b[i] = 8'($urandom);
        if (n == 5) arg = arg + (32'(b[i]) << (8 * (i - 1)));
      end
      txq.delete();
      e0 = exec_cnt;
      for (int i = 0; i < n; i++) begin
        idle($urandom_range(0, 3));
        send(b[i]);
      end
      if (b[0] != 8'h02) begin
        m_opc = b[0];
        m_arg = arg;
      end
      check("rnd_exec", {31'd0, exec_o}, {31'd0, b[0] != 8'h02});
      check("rnd_opc", {24'd0, opc_o}, {24'd0, m_opc});
      check("rnd_arg", arg_o, m_arg);
      check("rnd_srst", {31'd0, soft_rst_o}, {31'd0, b[0] == 8'h00});
      @(negedge clk);
      #1;
      check("rnd_exec_cnt", exec_cnt - e0, {31'd0, b[0] != 8'h02});
      if (b[0] == 8'h02) expect_id("rnd");
    end
    check("err_total", err_cnt, 32'd1 * 0 + (`ifdef LOGIP_RX_TIMEOUT_EN 32'd1 `else 32'd0 `endif));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
